// File: rtl/map_ram_reader_if.sv
// Signal bundle between the map RAM reader and its surroundings.
//   line_start/line_y : display line prefetch trigger and pixel row
//   pixel_x           : current pixel column
//   rdaddr/rddata     : map RAM read port (row address, 160-bit row)
//   cell_code/valid   : per-pixel cell code to the tile renderer
//   query_*           : single-cell lookup req/ack port
//   busy              : reader is not idle
interface map_ram_reader_if;
  logic         line_start;
  logic [8:0]   line_y;
  logic [9:0]   pixel_x;
  logic [4:0]   rdaddr;
  logic [159:0] rddata;
  logic [3:0]   cell_code;
  logic         cell_valid;
  logic         query_req;
  logic [5:0]   query_x;
  logic [4:0]   query_y;
  logic         query_ack;
  logic [3:0]   query_data;
  logic         busy;

  // Reader side
  modport slave (
    input  line_start, line_y, pixel_x, rddata, query_req, query_x, query_y,
    output rdaddr, cell_code, cell_valid, query_ack, query_data, busy
  );

  // Environment side (video timing, RAM, requester)
  modport master (
    output line_start, line_y, pixel_x, rddata, query_req, query_x, query_y,
    input  rdaddr, cell_code, cell_valid, query_ack, query_data, busy
  );
endinterface

// File: rtl/map_ram_reader.sv
// Read side of the 30x40 map RAM. Prefetches one map row per display line
// into a line buffer, streams per-pixel cell codes, and serves single-cell
// lookups through a req/ack port sharing the single RAM read port.
// Ports:
//   CLOCK_50 : system clock
//   reset    : asynchronous active-low reset
//   bus      : map_ram_reader_if.slave (display, RAM read port, query port)
module map_ram_reader #(
  parameter int unsigned ROWS       = 30,
  parameter int unsigned COLS       = 40,
  parameter int unsigned TILE_SHIFT = 4,
  parameter int unsigned H_ACTIVE   = 640
) (
  input logic              CLOCK_50,
  input logic              reset,
  map_ram_reader_if.slave  bus
);

  localparam int unsigned ROW_W  = 4 * COLS;
  localparam logic [4:0]  ROWS_L = 5'(ROWS);
  localparam logic [5:0]  COLS_L = 6'(COLS);
  localparam logic [9:0]  HACT_L = 10'(H_ACTIVE);

  typedef enum logic [2:0] {IDLE, D_ADDR, D_LATCH, Q_ADDR, Q_LATCH} state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] line_buf;
  logic [4:0]       line_row;
  logic             line_pend;
  logic [5:0]       q_x;

  logic [4:0] ls_row;
  logic       ls_valid, ls_drop, q_oor;
  logic       disp_go, qry_go, oor_ack, line_done, qry_done;

  // Cell 0 sits in the MSBs of a row
  function automatic logic [3:0] cell_of(input logic [ROW_W-1:0] row,
                                         input logic [5:0]       col);
    logic [5:0] rev;
    rev = COLS_L - 6'd1 - col;
    return row[{rev, 2'b00} +: 4];
  endfunction

  assign ls_row   = 5'(bus.line_y >> TILE_SHIFT);
  assign ls_valid = bus.line_start && (ls_row < ROWS_L);
  assign ls_drop  = bus.line_start && !(ls_row < ROWS_L);
  assign q_oor    = (bus.query_x >= COLS_L) || (bus.query_y >= ROWS_L);

  // Next state and strobes. A line_start arriving in IDLE counts as pending
  // so the display fetch wins over a simultaneous query. A query is not
  // accepted while an ack is showing, which keeps a still-high req from
  // being served twice.
  always_comb begin
    state_d   = state_q;
    disp_go   = 1'b0;
    qry_go    = 1'b0;
    oor_ack   = 1'b0;
    line_done = 1'b0;
    qry_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ls_valid || line_pend) begin
          state_d = D_ADDR;
          disp_go = 1'b1;
        end else if (bus.query_req && !bus.query_ack) begin
          if (q_oor) begin
            oor_ack = 1'b1;
          end else begin
            state_d = Q_ADDR;
            qry_go  = 1'b1;
          end
        end
      end
      D_ADDR:  state_d = D_LATCH;
      D_LATCH: begin
        line_done = 1'b1;
        state_d   = IDLE;
      end
      Q_ADDR:  state_d = Q_LATCH;
      Q_LATCH: begin
        qry_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fetch bookkeeping and query outputs
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      line_buf       <= '0;
      line_row       <= '0;
      line_pend      <= 1'b0;
      q_x            <= '0;
      bus.rdaddr     <= '0;
      bus.query_ack  <= 1'b0;
      bus.query_data <= '0;
      bus.busy       <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.busy <= (state_d != IDLE);

      if (ls_valid) line_row <= ls_row;

      // Pending is consumed when the fetch is dispatched; a later line_start
      // re-arms it so a newer row is never lost behind an in-flight fetch.
      if (disp_go)       line_pend <= 1'b0;
      else if (ls_valid) line_pend <= 1'b1;

      if (disp_go)     bus.rdaddr <= ls_valid ? ls_row : line_row;
      else if (qry_go) bus.rdaddr <= bus.query_y;

      // Column is captured so a dropped req cannot corrupt the in-flight lookup
      if (qry_go) q_x <= bus.query_x;

      if (ls_drop)        line_buf <= '0;
      else if (line_done) line_buf <= bus.rddata;

      bus.query_ack <= oor_ack || qry_done;
      if (qry_done)     bus.query_data <= cell_of(bus.rddata, q_x);
      else if (oor_ack) bus.query_data <= '0;
    end
  end

  // Pixel path: cell under pixel_x, one cycle latency
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bus.cell_code  <= '0;
      bus.cell_valid <= 1'b0;
    end else if (bus.pixel_x < HACT_L) begin
      bus.cell_code  <= cell_of(line_buf, 6'(bus.pixel_x >> TILE_SHIFT));
      bus.cell_valid <= 1'b1;
    end else begin
      bus.cell_code  <= '0;
      bus.cell_valid <= 1'b0;
    end
  end

endmodule
